// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the coefficient RAM word layout, used by both the
// CBD sampler (writer) and the polynomial byte encoder (reader).
package kyber_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int KYBER_N    = 256;
  localparam int COEFF_BITS = 12;

  // Two coefficients per RAM word, even-index coefficient in the low half.
  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
  } ram_word_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } enc_state_t;

  function automatic logic coeff_out_of_range(input logic [COEFF_BITS-1:0] c);
    return c >= COEFF_BITS'(KYBER_Q);
  endfunction

endpackage

// File: rtl/bit_packer_96.sv
// 96-bit LSB-first bit accumulator: appends 24 bits at the fill point and
// retires 64 bits from the bottom, both possibly in the same cycle.
module bit_packer_96
  import kyber_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic [23:0] push_data,
  input  logic        pop,
  output logic [63:0] head,
  output logic [6:0]  count,
  output logic [6:0]  count_next
);

  logic [95:0] bits_q, bits_d;
  logic [6:0]  count_q, count_d;
  logic [6:0]  base;
  logic [95:0] shifted;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    base    = pop ? count_q - 7'd64 : count_q;
    shifted = pop ? {64'd0, bits_q[95:64]} : bits_q;
    bits_d  = shifted;
    count_d = base;
    // Fresh bits land just above whatever survives this cycle's pop.
    if (push) begin
      bits_d  = shifted | ({72'd0, push_data} << base);
      count_d = base + 7'd24;
    end
    if (clear) begin
      bits_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: nonblocking assignments for all flops so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the buffer is a datapath register, not a memory, and is cleared so out_data reads 0 after reset.
      bits_q  <= '0;
      count_q <= '0;
    end else begin
      bits_q  <= bits_d;
      count_q <= count_d;
    end
  end

  assign head       = bits_q[63:0];
  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/poly_byte_encode.sv
// ByteEncode_12 of one polynomial from coefficient RAM into 64-bit stream words.
// Optional sticky range flag on output err: define POLY_BYTE_ENCODE_RANGE_CHECK_EN.
module poly_byte_encode
  import kyber_pkg::*;
#(
  parameter int NUM_WORDS = 128,
  parameter int ADDR_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic [63:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef POLY_BYTE_ENCODE_RANGE_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int NUM_OUT   = NUM_WORDS * 3 / 8;
  localparam int OUT_CNT_W = $clog2(NUM_OUT);
  localparam int RD_CNT_W  = ADDR_W + 1;
  localparam int OUT_LAST_I = NUM_OUT - 1;
  localparam logic [RD_CNT_W-1:0]  NUM_WORDS_C = NUM_WORDS[RD_CNT_W-1:0];
  localparam logic [OUT_CNT_W-1:0] OUT_LAST    = OUT_LAST_I[OUT_CNT_W-1:0];

  enc_state_t            state_q, state_d;
  logic [RD_CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [OUT_CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  done_q, done_d;

  ram_word_t   rd_word;
  logic [23:0] push_data;
  logic [7:0]  nibbles_unused;
  logic        clear;
  logic        fire;
  logic [6:0]  count;
  logic [6:0]  count_next;

  assign rd_word        = rd_data;
  assign push_data      = {rd_word.hi[COEFF_BITS-1:0], rd_word.lo[COEFF_BITS-1:0]};
  assign nibbles_unused = {rd_word.hi[15:12], rd_word.lo[15:12]};

  assign out_valid = (count >= 7'd64);
  assign fire      = out_valid && out_ready;

  bit_packer_96 u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .push       (rd_pend_q),
    .push_data  (push_data),
    .pop        (fire),
    .head       (out_data),
    .count      (count),
    .count_next (count_next)
  );

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    rd_pend_d = 1'b0;
    done_d    = 1'b0;
    rd_en     = 1'b0;
    clear     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
          clear     = 1'b1;
        end
      end
      ST_RUN: begin
        // A new read is only issued if its 24 bits still fit once the data in
        // flight this cycle has landed, so the buffer can never overflow.
        if (rd_cnt_q < NUM_WORDS_C && count_next <= 7'd72) begin
          rd_en     = 1'b1;
          rd_pend_d = 1'b1;
          rd_cnt_d  = rd_cnt_q + RD_CNT_W'(1);
        end
        if (fire) begin
          if (out_cnt_q == OUT_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            out_cnt_d = out_cnt_q + OUT_CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      out_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      out_cnt_q <= out_cnt_d;
      rd_pend_q <= rd_pend_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = done_q;
  assign rd_addr = rd_cnt_q[ADDR_W-1:0];

`ifdef POLY_BYTE_ENCODE_RANGE_CHECK_EN
  logic err_q, err_d;

  // Flag tracks coefficients as they enter the buffer; encoding is unaffected.
  always_comb begin
    err_d = err_q;
    if (clear) begin
      err_d = 1'b0;
    end else if (rd_pend_q && (coeff_out_of_range(rd_word.lo[COEFF_BITS-1:0]) ||
                               coeff_out_of_range(rd_word.hi[COEFF_BITS-1:0]))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
